spi_regfile_periph: RTL and testbench

//  SPI (mode 0) peripheral feeding a parametrised bank of NUM_REGS config registers, DATA_W bits each.

---
 rtl/spi_regfile_periph_if.sv | 11 +
 rtl/spi_regfile_periph.sv | 180 ++++++++++++++++++
 tb/tb_spi_regfile_periph.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_regfile_periph_if.sv
// SPI pin bundle for spi_regfile_periph: controller (master) drives sclk/copi/ncs,
// peripheral (slave) drives cipo.
interface spi_regfile_periph_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;

    modport master (output sclk, output copi, output ncs, input cipo);
    modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral writing a bank of NUM_REGS x DATA_W config registers.
// Optional register read-back on cipo is enabled by defining SPI_READBACK_EN.
module spi_regfile_periph #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    spi_regfile_periph_if.slave        spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_LEN + 1);
    localparam logic [ADDR_W:0]   NREGS    = (ADDR_W + 1)'(NUM_REGS);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   ncs_hist_q, ncs_hist_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]   rx_q, rx_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic                   frame_err_q, frame_err_d;

    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_rise, ncs_fall;
    logic [FRAME_LEN-1:0] rx_shift;
    logic                 rx_rw;
    logic [ADDR_W-1:0]    rx_addr;
    logic [DATA_W-1:0]    rx_data;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign ncs_rise  = ncs_s & ~ncs_hist_q;
    assign ncs_fall  = ~ncs_s & ncs_hist_q;
    assign rx_shift  = {rx_q[FRAME_LEN-2:0], copi_s};
    assign rx_rw     = rx_q[FRAME_LEN-1];
    assign rx_addr   = rx_q[DATA_W +: ADDR_W];
    assign rx_data   = rx_q[DATA_W-1:0];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
        sclk_hist_d = sclk_s;
        ncs_hist_d  = ncs_s;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;

        // ncs edges outrank a coincident sclk edge
        if (ncs_fall) begin
            cnt_d = '0;
            rx_d  = '0;
        end else if (ncs_rise) begin
            if (rx_rw) begin
                if (cnt_q == CNT_FULL && {1'b0, rx_addr} < NREGS) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (rx_addr == ADDR_W'(i)) regs_d[i*DATA_W +: DATA_W] = rx_data;
                    end
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = rx_addr;
                end else begin
                    frame_err_d = 1'b1;
                end
            end else if (cnt_q != CNT_FULL) begin
                frame_err_d = 1'b1;
            end
        end else if (!ncs_s && sclk_rise) begin
            rx_d = rx_shift;
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b1;
            cnt_q       <= '0;
            rx_q        <= '0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_hist_q <= sclk_hist_d;
            ncs_hist_q  <= ncs_hist_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign regs_out  = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
    localparam int TX_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);

    logic              sclk_fall;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [TX_W-1:0]   tx_left_q, tx_left_d;
    logic              cipo_q, cipo_d;
    logic [DATA_W-1:0] rd_word;

    assign sclk_fall = ~sclk_s & sclk_hist_q;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rx_shift[ADDR_W-1:0] == ADDR_W'(i)) rd_word = regs_q[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        tx_d      = tx_q;
        tx_left_d = tx_left_q;
        cipo_d    = cipo_q;
        if (ncs_s || ncs_fall) begin
            tx_left_d = '0;
            cipo_d    = 1'b0;
        end else if (sclk_rise && cnt_q == CNT_ADDR && !rx_shift[ADDR_W]) begin
            // last address bit of a read frame just arrived
            tx_d      = rd_word;
            tx_left_d = TX_W'(DATA_W);
        end else if (sclk_fall) begin
            if (tx_left_q != '0) begin
                cipo_d    = tx_q[DATA_W-1];
                tx_d      = {tx_q[DATA_W-2:0], 1'b0};
                tx_left_d = tx_left_q - TX_W'(1);
            end else begin
                cipo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q      <= '0;
            tx_left_q <= '0;
            cipo_q    <= 1'b0;
        end else begin
            tx_q      <= tx_d;
            tx_left_q <= tx_left_d;
            cipo_q    <= cipo_d;
        end
    end

    assign spi.cipo = cipo_q;
`else
    assign spi.cipo = 1'b0;
`endif
endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph at default parameters (sclk half-period 8 clk).
module tb_spi_regfile_periph;
    logic        clk;
    logic        rst;
    logic [39:0] regs_out;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic        frame_err;

    int tests_run;
    int tests_failed;
    int strobe_cnt;
    int err_cnt;

    spi_regfile_periph_if spi_bus ();

    spi_regfile_periph dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi_bus),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobe_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends nbits of 'bits' MSB first; rd collects cipo before each data-bit rise of a 16-bit frame.
    task automatic spi_frame(input logic [31:0] bits, input int nbits, output logic [7:0] rd);
        rd = 8'h00;
        spi_bus.ncs = 1'b0;
        wait_clk(8);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bus.copi = bits[i];
            wait_clk(8);
            if (nbits == 16 && i < 8) rd[i] = spi_bus.cipo;
            spi_bus.sclk = 1'b1;
            wait_clk(8);
            spi_bus.sclk = 1'b0;
        end
        wait_clk(8);
        spi_bus.ncs  = 1'b1;
        spi_bus.copi = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(2);
        tests_run++;
        if (regs_out !== 40'h0) begin tests_failed++; $display("FAIL reset_regs: got %h expected %h", regs_out, 40'h0); end
        tests_run++;
        if (wr_strobe !== 1'b0) begin tests_failed++; $display("FAIL reset_strobe: got %b expected 0", wr_strobe); end
        tests_run++;
        if (wr_addr !== 7'h0) begin tests_failed++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
        tests_run++;
        if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        tests_run++;
        if (spi_bus.cipo !== 1'b0) begin tests_failed++; $display("FAIL reset_cipo: got %b expected 0", spi_bus.cipo); end
    endtask

    task automatic test_write_basic();
        logic [7:0] rd;
        strobe_cnt = 0; err_cnt = 0;
        spi_frame(32'h80A5, 16, rd);
        wait_clk(20);
        tests_run++;
        if (regs_out !== 40'h00_00_00_00_A5) begin tests_failed++; $display("FAIL write0_regs: got %h expected %h", regs_out, 40'h00000000A5); end
        tests_run++;
        if (strobe_cnt !== 1) begin tests_failed++; $display("FAIL write0_strobes: got %0d expected 1", strobe_cnt); end
        tests_run++;
        if (wr_addr !== 7'd0) begin tests_failed++; $display("FAIL write0_wr_addr: got %h expected 0", wr_addr); end
        tests_run++;
        if (err_cnt !== 0) begin tests_failed++; $display("FAIL write0_err: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_bad_addr();
        logic [7:0] rd;
        strobe_cnt = 0; err_cnt = 0;
        spi_frame(32'h843C, 16, rd);
        wait_clk(20);
        tests_run++;
        if (regs_out !== 40'h3C_00_00_00_A5) begin tests_failed++; $display("FAIL write4_regs: got %h expected %h", regs_out, 40'h3C000000A5); end
        tests_run++;
        if (wr_addr !== 7'd4) begin tests_failed++; $display("FAIL write4_wr_addr: got %h expected 4", wr_addr); end
        strobe_cnt = 0; err_cnt = 0;
        spi_frame(32'h85FF, 16, rd);
        wait_clk(20);
        tests_run++;
        if (regs_out !== 40'h3C_00_00_00_A5) begin tests_failed++; $display("FAIL addr5_regs: got %h expected %h", regs_out, 40'h3C000000A5); end
        tests_run++;
        if (err_cnt !== 1) begin tests_failed++; $display("FAIL addr5_err: got %0d expected 1", err_cnt); end
        tests_run++;
        if (strobe_cnt !== 0) begin tests_failed++; $display("FAIL addr5_strobes: got %0d expected 0", strobe_cnt); end
    endtask

    task automatic test_bad_length();
        logic [7:0] rd;
        strobe_cnt = 0; err_cnt = 0;
        spi_frame(32'h817, 12, rd);
        wait_clk(20);
        tests_run++;
        if (regs_out !== 40'h3C_00_00_00_A5) begin tests_failed++; $display("FAIL len12_regs: got %h expected %h", regs_out, 40'h3C000000A5); end
        tests_run++;
        if (err_cnt !== 1 || strobe_cnt !== 0) begin tests_failed++; $display("FAIL len12_pulses: got err=%0d strobe=%0d expected err=1 strobe=0", err_cnt, strobe_cnt); end
        strobe_cnt = 0; err_cnt = 0;
        spi_frame(32'h102EE, 17, rd);
        wait_clk(20);
        tests_run++;
        if (regs_out !== 40'h3C_00_00_00_A5) begin tests_failed++; $display("FAIL len17_regs: got %h expected %h", regs_out, 40'h3C000000A5); end
        tests_run++;
        if (err_cnt !== 1 || strobe_cnt !== 0) begin tests_failed++; $display("FAIL len17_pulses: got err=%0d strobe=%0d expected err=1 strobe=0", err_cnt, strobe_cnt); end
    endtask

    task automatic test_readback();
        logic [7:0] rd;
        logic [7:0] exp_rd;
        spi_frame(32'h825A, 16, rd);
        wait_clk(20);
        tests_run++;
        if (regs_out !== 40'h3C_00_5A_00_A5) begin tests_failed++; $display("FAIL write2_regs: got %h expected %h", regs_out, 40'h3C005A00A5); end
        strobe_cnt = 0; err_cnt = 0;
        spi_frame(32'h0200, 16, rd);
        wait_clk(20);
`ifdef SPI_READBACK_EN
        exp_rd = 8'h5A;
`else
        exp_rd = 8'h00;
`endif
        tests_run++;
        if (rd !== exp_rd) begin tests_failed++; $display("FAIL read2_cipo: got %h expected %h", rd, exp_rd); end
        tests_run++;
        if (regs_out !== 40'h3C_00_5A_00_A5) begin tests_failed++; $display("FAIL read2_regs: got %h expected %h", regs_out, 40'h3C005A00A5); end
        tests_run++;
        if (err_cnt !== 0 || strobe_cnt !== 0) begin tests_failed++; $display("FAIL read2_pulses: got err=%0d strobe=%0d expected 0/0", err_cnt, strobe_cnt); end
        tests_run++;
        if (spi_bus.cipo !== 1'b0) begin tests_failed++; $display("FAIL read2_cipo_idle: got %b expected 0", spi_bus.cipo); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] rd;
        logic [15:0] w;
        w = 16'h8177;
        spi_bus.ncs = 1'b0;
        wait_clk(8);
        for (int i = 15; i >= 7; i--) begin
            spi_bus.copi = w[i];
            wait_clk(8);
            spi_bus.sclk = 1'b1;
            wait_clk(8);
            spi_bus.sclk = 1'b0;
        end
        rst = 1'b1;
        wait_clk(2);
        tests_run++;
        if (regs_out !== 40'h0 || wr_addr !== 7'h0) begin tests_failed++; $display("FAIL midrst_regs: got regs=%h addr=%h expected 0/0", regs_out, wr_addr); end
        tests_run++;
        if (wr_strobe !== 1'b0 || frame_err !== 1'b0 || spi_bus.cipo !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_pulses: got strobe=%b err=%b cipo=%b expected 0", wr_strobe, frame_err, spi_bus.cipo);
        end
        rst = 1'b0;
        spi_bus.copi = 1'b0;
        spi_bus.ncs  = 1'b1;
        wait_clk(20);
        tests_run++;
        if (regs_out !== 40'h0) begin tests_failed++; $display("FAIL midrst_discard: got %h expected 0", regs_out); end
        strobe_cnt = 0;
        spi_frame(32'h8381, 16, rd);
        wait_clk(20);
        tests_run++;
        if (regs_out !== 40'h00_81_00_00_00) begin tests_failed++; $display("FAIL write3_regs: got %h expected %h", regs_out, 40'h0081000000); end
        tests_run++;
        if (strobe_cnt !== 1 || wr_addr !== 7'd3) begin tests_failed++; $display("FAIL write3_strobe: got strobe=%0d addr=%h expected 1/3", strobe_cnt, wr_addr); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        strobe_cnt = 0; err_cnt = 0;
        spi_frame(32'h8011, 16, rd);
        wait_clk(4);
        spi_frame(32'h8122, 16, rd);
        wait_clk(20);
        tests_run++;
        if (regs_out !== 40'h00_81_00_22_11) begin tests_failed++; $display("FAIL b2b_regs: got %h expected %h", regs_out, 40'h0081002211); end
        tests_run++;
        if (strobe_cnt !== 2) begin tests_failed++; $display("FAIL b2b_strobes: got %0d expected 2", strobe_cnt); end
        tests_run++;
        if (wr_addr !== 7'd1 || err_cnt !== 0) begin tests_failed++; $display("FAIL b2b_addr_err: got addr=%h err=%0d expected 1/0", wr_addr, err_cnt); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        strobe_cnt   = 0;
        err_cnt      = 0;
        rst          = 1'b1;
        spi_bus.sclk = 1'b0;
        spi_bus.copi = 1'b0;
        spi_bus.ncs  = 1'b1;
        test_reset();
        test_write_basic();
        test_bad_addr();
        test_bad_length();
        test_readback();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
